// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter: round-robin, packet-locking arbiter feeding one UART TX.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int         NREQ         = 4,
  parameter logic [7:0] UART_ADDRESS = 8'h00,
  parameter logic [7:0] BAUD_DIV     = 8'd6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [8*NREQ-1:0]    req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic [7:0]           uart_address,
  output logic [7:0]           uart_din,
  output logic                 uart_w_en,
  output logic                 uart_r_en,
  input  logic [7:0]           uart_dout
);

  localparam int         IW           = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] ADDR_CTRL    = UART_ADDRESS + 8'd1;
  localparam logic [7:0] ADDR_BUF     = UART_ADDRESS + 8'd2;
  localparam int         TX_EMPTY_BIT = 1;

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    IDLE     = 3'd1,
    POLL_RD  = 3'd2,
    POLL_CHK = 3'd3,
    WRITE    = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic            baud_done, baud_done_nxt;
  logic            locked, locked_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [IW-1:0]   owner, owner_nxt;
  logic [7:0]      hold_data, hold_data_nxt;
  logic            hold_last, hold_last_nxt;
  logic [NREQ-1:0] grant_nxt, req_ready_nxt;
  logic [7:0]      addr_nxt, din_nxt;
  logic            w_en_nxt, r_en_nxt;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   sel_idx;
  logic            sel_valid;
  logic [7:0]      sel_data;
  logic            sel_last;
  logic            unused_dout;

  // Only the tx_empty flag of the control register matters here.
  assign unused_dout = ^{uart_dout[7:TX_EMPTY_BIT+1], uart_dout[TX_EMPTY_BIT-1:0]};

  // First valid requester at or after ptr+1, wrapping.
  always_comb begin
    int idx;
    logic [IW-1:0] idx_t;
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    idx_t      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx   = (int'(ptr) + k) % NREQ;
      idx_t = IW'(idx);
      if (!pick_found && req_valid[idx_t]) begin
        pick_found = 1'b1;
        pick_idx   = idx_t;
      end
    end
  end

  // A locked packet keeps its owner; otherwise take the round-robin pick.
  assign sel_idx   = locked ? owner : pick_idx;
  assign sel_valid = locked ? req_valid[owner] : pick_found;
  assign sel_data  = req_data[{sel_idx, 3'b000} +: 8];
  assign sel_last  = req_last[sel_idx];

  always_comb begin
    state_nxt     = state;
    baud_done_nxt = baud_done;
    locked_nxt    = locked;
    ptr_nxt       = ptr;
    owner_nxt     = owner;
    hold_data_nxt = hold_data;
    hold_last_nxt = hold_last;
    grant_nxt     = grant;

    case (state)
      INIT: begin
        // First pass through INIT issues the baud write, second moves on.
        baud_done_nxt = 1'b1;
        if (baud_done) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (sel_valid) begin
          owner_nxt     = sel_idx;
          hold_data_nxt = sel_data;
          hold_last_nxt = sel_last;
          grant_nxt     = NREQ'(1) << sel_idx;
          state_nxt     = POLL_RD;
        end
      end
      POLL_RD: begin
        state_nxt = POLL_CHK;
      end
      POLL_CHK: begin
        state_nxt = uart_dout[TX_EMPTY_BIT] ? WRITE : POLL_RD;
      end
      WRITE: begin
        state_nxt = IDLE;
        if (hold_last) begin
          locked_nxt = 1'b0;
          ptr_nxt    = owner;
          grant_nxt  = '0;
        end else begin
          locked_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = INIT;
      end
    endcase

    // Bus outputs are registered, so decode them from the state being entered.
    addr_nxt      = ADDR_CTRL;
    din_nxt       = 8'h00;
    w_en_nxt      = 1'b0;
    r_en_nxt      = 1'b0;
    req_ready_nxt = '0;
    case (state_nxt)
      INIT: begin
        addr_nxt = UART_ADDRESS;
        din_nxt  = BAUD_DIV;
        w_en_nxt = 1'b1;
      end
      POLL_RD: begin
        r_en_nxt = 1'b1;
      end
      WRITE: begin
        addr_nxt      = ADDR_BUF;
        din_nxt       = hold_data_nxt;
        w_en_nxt      = 1'b1;
        req_ready_nxt = grant_nxt;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= INIT;
      baud_done    <= 1'b0;
      locked       <= 1'b0;
      ptr          <= IW'(NREQ - 1);
      owner        <= '0;
      hold_data    <= 8'h00;
      hold_last    <= 1'b0;
      grant        <= '0;
      req_ready    <= '0;
      uart_address <= UART_ADDRESS;
      uart_din     <= 8'h00;
      uart_w_en    <= 1'b0;
      uart_r_en    <= 1'b0;
    end else begin
      state        <= state_nxt;
      baud_done    <= baud_done_nxt;
      locked       <= locked_nxt;
      ptr          <= ptr_nxt;
      owner        <= owner_nxt;
      hold_data    <= hold_data_nxt;
      hold_last    <= hold_last_nxt;
      grant        <= grant_nxt;
      req_ready    <= req_ready_nxt;
      uart_address <= addr_nxt;
      uart_din     <= din_nxt;
      uart_w_en    <= w_en_nxt;
      uart_r_en    <= r_en_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_arbiter: directed vectors for the UART TX arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [8*NREQ-1:0]    req_data;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      grant;
  logic                 busy;
  logic [7:0]           uart_address;
  logic [7:0]           uart_din;
  logic                 uart_w_en;
  logic                 uart_r_en;
  logic [7:0]           uart_dout = 8'h00;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NREQ(NREQ),
    .UART_ADDRESS(8'h00),
    .BAUD_DIV(8'd6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .grant(grant),
    .busy(busy),
    .uart_address(uart_address),
    .uart_din(uart_din),
    .uart_w_en(uart_w_en),
    .uart_r_en(uart_r_en),
    .uart_dout(uart_dout)
  );

  int n_vec = 0;
  int n_err = 0;
  int reads_seen = 0;
  int fail_until = 0;
  int excl_viol = 0;

  // UART control register: registered read, tx_empty forced low for a window of reads.
  always @(posedge clk) begin
    if (uart_r_en && uart_address == 8'h01) begin
      uart_dout  <= (reads_seen < fail_until) ? 8'h00 : 8'h02;
      reads_seen <= reads_seen + 1;
    end
  end

  logic [8:0] q [NREQ][$];

  typedef struct {
    logic [7:0]      data;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] ready;
  } wr_t;
  wr_t writes[$];

  typedef struct {
    int         req;
    logic [7:0] data;
    logic       last;
    int         grp;
    int         exp_req;
    logic [7:0] exp_data;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if (q[i].size() > 0) begin
        req_valid[i]        = 1'b1;
        req_data[8*i +: 8]  = q[i][0][7:0];
        req_last[i]         = q[i][0][8];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[8*i +: 8]  = 8'h00;
        req_last[i]         = 1'b0;
      end
    end
  endtask

  // One clock: sample just after the edge, record buffer writes, advance requesters.
  task automatic step();
    @(posedge clk);
    #1;
    if (uart_r_en && uart_w_en) excl_viol++;
    if (uart_w_en && uart_address == 8'h02)
      writes.push_back('{data: uart_din, grant: grant, ready: req_ready});
    for (int i = 0; i < NREQ; i++)
      if (req_ready[i] && q[i].size() > 0) void'(q[i].pop_front());
    drive_inputs();
  endtask

  task automatic run_group(input int g);
    int base;
    int n;
    int j;
    base = writes.size();
    n = 0;
    for (int k = 0; k < 11; k++) begin
      if (tbl[k].grp == g) begin
        q[tbl[k].req].push_back({tbl[k].last, tbl[k].data});
        n++;
      end
    end
    drive_inputs();
    for (int c = 0; c < 300 && writes.size() < base + n; c++) step();
    check($sformatf("grp%0d_write_count", g), 32'(writes.size()), 32'(base + n));
    j = 0;
    for (int k = 0; k < 11; k++) begin
      if (tbl[k].grp == g) begin
        if (base + j < writes.size()) begin
          check($sformatf("grp%0d_w%0d_data", g, j), 32'(writes[base+j].data), 32'(tbl[k].exp_data));
          check($sformatf("grp%0d_w%0d_grant", g, j), 32'(writes[base+j].grant), 32'(1) << tbl[k].exp_req);
          check($sformatf("grp%0d_w%0d_ready", g, j), 32'(writes[base+j].ready), 32'(1) << tbl[k].exp_req);
        end
        j++;
      end
    end
  endtask

  initial begin
    int act;
    int nr, first_rd, last_rd, wr_at, odd_bad, early_ready;
    logic [7:0] wr_din;
    int base;

    tbl[0]  = '{0, 8'hA0, 1'b1, 0, 0, 8'hA0};
    tbl[1]  = '{0, 8'hA1, 1'b1, 0, 1, 8'hB0};
    tbl[2]  = '{1, 8'hB0, 1'b1, 0, 3, 8'hD0};
    tbl[3]  = '{1, 8'hB1, 1'b1, 0, 0, 8'hA1};
    tbl[4]  = '{3, 8'hD0, 1'b1, 0, 1, 8'hB1};
    tbl[5]  = '{3, 8'hD1, 1'b1, 0, 3, 8'hD1};
    tbl[6]  = '{0, 8'hE0, 1'b1, 1, 0, 8'hE0};
    tbl[7]  = '{0, 8'hE1, 1'b1, 1, 1, 8'h1A};
    tbl[8]  = '{1, 8'h1A, 1'b0, 1, 1, 8'h1B};
    tbl[9]  = '{1, 8'h1B, 1'b0, 1, 1, 8'h1C};
    tbl[10] = '{1, 8'h1C, 1'b1, 1, 0, 8'hE1};

    rst = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;

    // Reset values
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_w_en", 32'(uart_w_en), 32'h0);
    check("rst_r_en", 32'(uart_r_en), 32'h0);
    check("rst_addr", 32'(uart_address), 32'h00);
    check("rst_din", 32'(uart_din), 32'h00);
    check("rst_busy", 32'(busy), 32'h1);

    // Baud write in the first cycle after release, then quiet IDLE
    @(negedge clk);
    rst = 1'b1;
    step();
    check("baud_w_en", 32'(uart_w_en), 32'h1);
    check("baud_addr", 32'(uart_address), 32'h00);
    check("baud_din", 32'(uart_din), 32'h06);
    check("baud_r_en", 32'(uart_r_en), 32'h0);
    step();
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_w_en", 32'(uart_w_en), 32'h0);
    act = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (uart_w_en || uart_r_en || busy) act++;
    end
    check("idle_quiet", 32'(act), 32'h0);

    // Single byte on requester 2, tx_empty already set
    q[2].push_back({1'b1, 8'hA5});
    drive_inputs();
    step();
    check("s_pollrd_r_en", 32'(uart_r_en), 32'h1);
    check("s_pollrd_addr", 32'(uart_address), 32'h01);
    check("s_pollrd_grant", 32'(grant), 32'h4);
    check("s_pollrd_ready", 32'(req_ready), 32'h0);
    step();
    check("s_pollchk_en", 32'({uart_r_en, uart_w_en}), 32'h0);
    step();
    check("s_write_w_en", 32'(uart_w_en), 32'h1);
    check("s_write_addr", 32'(uart_address), 32'h02);
    check("s_write_din", 32'(uart_din), 32'hA5);
    check("s_write_ready", 32'(req_ready), 32'h4);
    step();
    check("s_after_grant", 32'(grant), 32'h0);
    check("s_after_ready", 32'(req_ready), 32'h0);
    check("s_after_busy", 32'(busy), 32'h0);

    // tx_empty low for three polls, requester 3
    fail_until = reads_seen + 3;
    q[3].push_back({1'b1, 8'h3C});
    drive_inputs();
    nr = 0; first_rd = -1; last_rd = -1; wr_at = -1; odd_bad = 0; early_ready = 0;
    wr_din = 8'h00;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (uart_r_en) begin
        nr++;
        if (first_rd < 0) first_rd = c;
        last_rd = c;
        if ((c % 2) == 0 || uart_address != 8'h01) odd_bad++;
      end
      if (req_ready != '0 && !uart_w_en) early_ready++;
      if (uart_w_en && uart_address == 8'h02) begin
        wr_at = c;
        wr_din = uart_din;
        break;
      end
    end
    check("p_reads", 32'(nr), 32'd4);
    check("p_first_rd", 32'(first_rd), 32'd1);
    check("p_last_rd", 32'(last_rd), 32'd7);
    check("p_rd_pattern", 32'(odd_bad), 32'd0);
    check("p_write_at", 32'(wr_at), 32'd9);
    check("p_write_din", 32'(wr_din), 32'h3C);
    check("p_early_ready", 32'(early_ready), 32'd0);

    // Round robin with wrap, then a locked packet with a waiting competitor
    run_group(0);
    run_group(1);

    // Reset during POLL_CHK of a locked packet
    base = writes.size();
    q[1].push_back({1'b0, 8'h2A});
    q[1].push_back({1'b0, 8'h2B});
    q[1].push_back({1'b1, 8'h2C});
    drive_inputs();
    for (int c = 0; c < 50 && writes.size() < base + 1; c++) step();
    check("r_first_count", 32'(writes.size()), 32'(base + 1));
    if (writes.size() > base) check("r_first_data", 32'(writes[base].data), 32'h2A);
    q[0].push_back({1'b1, 8'hF0});
    drive_inputs();
    act = 0;
    for (int c = 0; c < 50 && !uart_r_en; c++) begin
      step();
      act++;
    end
    check("r_poll_seen", 32'(uart_r_en), 32'h1);
    step();
    check("r_pollchk_en", 32'({uart_r_en, uart_w_en}), 32'h0);
    #1;
    rst = 1'b0;
    #1;
    check("r_async_w_en", 32'(uart_w_en), 32'h0);
    check("r_async_r_en", 32'(uart_r_en), 32'h0);
    check("r_async_ready", 32'(req_ready), 32'h0);
    check("r_async_grant", 32'(grant), 32'h0);
    check("r_async_busy", 32'(busy), 32'h1);
    check("r_async_addr", 32'(uart_address), 32'h00);
    q[1].delete();
    q[1].push_back({1'b1, 8'h2D});
    drive_inputs();
    @(posedge clk);
    #1;
    check("r_hold_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    base = writes.size();
    step();
    check("r_baud_w_en", 32'(uart_w_en), 32'h1);
    check("r_baud_addr", 32'(uart_address), 32'h00);
    check("r_baud_din", 32'(uart_din), 32'h06);
    for (int c = 0; c < 100 && writes.size() < base + 2; c++) step();
    check("r_post_count", 32'(writes.size()), 32'(base + 2));
    if (writes.size() >= base + 2) begin
      check("r_post0_data", 32'(writes[base].data), 32'hF0);
      check("r_post0_grant", 32'(writes[base].grant), 32'h1);
      check("r_post1_data", 32'(writes[base+1].data), 32'h2D);
      check("r_post1_grant", 32'(writes[base+1].grant), 32'h2);
    end

    check("rw_exclusive", 32'(excl_viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
